// File: rtl/scan_display_n.sv
// Multiplexed N-digit display scanner with per-frame input snapshot and blanking.
// Optional leading-zero suppression is enabled by defining SCAN_LZ_SUPPRESS_EN.
module scan_display_n #(
    parameter  int NUM_DIGITS = 4,
    parameter  int DIGIT_W    = 4,
    parameter  int PRESCALE   = 1,
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                          scan_clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] num_in,
    input  logic [NUM_DIGITS-1:0]         blank_mask,
    output logic [DIGIT_W-1:0]            num_out,
    output logic [IDX_W-1:0]              index,
    output logic [NUM_DIGITS-1:0]         digit_en,
    output logic                          frame_done
);

    localparam int                PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]   PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [PS_W-1:0]               presc;
    logic [NUM_DIGITS*DIGIT_W-1:0] snap_num;
    logic [NUM_DIGITS-1:0]         snap_blank;

    logic                          step;
    logic                          wrap;
    logic [IDX_W-1:0]              idx_nx;
    logic [NUM_DIGITS*DIGIT_W-1:0] src_num;
    logic [NUM_DIGITS-1:0]         src_blank;
    logic [NUM_DIGITS-1:0]         dark;
    logic [DIGIT_W-1:0]            digit_nx;
    logic [NUM_DIGITS-1:0]         den_nx;

    // On the wrap edge digit 0 is taken from the live inputs being captured,
    // so every digit of a frame comes from the same capture.
    always_comb begin
        step      = en && (presc == PS_LAST);
        idx_nx    = (index == IDX_LAST) ? '0 : index + 1'b1;
        wrap      = step && (idx_nx == '0);
        src_num   = wrap ? num_in : snap_num;
        src_blank = wrap ? blank_mask : snap_blank;
        digit_nx  = src_num[idx_nx*DIGIT_W +: DIGIT_W];
    end

`ifdef SCAN_LZ_SUPPRESS_EN
    logic [NUM_DIGITS-1:0] lz_dark;
    logic                  all_zero;

    // Scan from the top digit down; digit 0 is never suppressed.
    always_comb begin
        lz_dark  = '0;
        all_zero = 1'b1;
        for (int unsigned k = 0; k < NUM_DIGITS - 1; k++) begin
            all_zero = all_zero && (src_num[(NUM_DIGITS-1-k)*DIGIT_W +: DIGIT_W] == '0);
            lz_dark[NUM_DIGITS-1-k] = all_zero;
        end
    end

    always_comb dark = src_blank | lz_dark;
`else
    always_comb dark = src_blank;
`endif

    always_comb begin
        den_nx = '0;
        if (!dark[idx_nx])
            den_nx = NUM_DIGITS'(1) << idx_nx;
    end

    always_ff @(posedge scan_clk) begin
        if (rst) begin
            presc      <= '0;
            index      <= IDX_LAST;
            num_out    <= '0;
            digit_en   <= '0;
            frame_done <= 1'b0;
            snap_num   <= '0;
            snap_blank <= '0;
        end else begin
            frame_done <= 1'b0;
            if (en)
                presc <= step ? '0 : presc + 1'b1;
            if (step) begin
                index    <= idx_nx;
                num_out  <= digit_nx;
                digit_en <= den_nx;
                if (wrap) begin
                    snap_num   <= num_in;
                    snap_blank <= blank_mask;
                    frame_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_scan_display_n.sv
// Self-checking bench for scan_display_n: vector table on a 4-digit/PRESCALE=1
// instance plus a prescaled 3-digit instance, both checked through a scoreboard queue.
module tb_scan_display_n;

    localparam bit LZ =
`ifdef SCAN_LZ_SUPPRESS_EN
        1'b1;
`else
        1'b0;
`endif

    logic        clk;
    logic        rst, en;
    logic [15:0] num_in;
    logic [3:0]  blank_mask;
    logic [3:0]  num_out;
    logic [1:0]  index;
    logic [3:0]  digit_en;
    logic        frame_done;

    logic        rst2, en2;
    logic [11:0] num_in2;
    logic [2:0]  blank2;
    logic [3:0]  num_out2;
    logic [1:0]  index2;
    logic [2:0]  digit_en2;
    logic        frame_done2;

    int total = 0;
    int bad   = 0;

    scan_display_n #(.NUM_DIGITS(4), .DIGIT_W(4), .PRESCALE(1)) dut (
        .scan_clk(clk), .rst(rst), .en(en), .num_in(num_in), .blank_mask(blank_mask),
        .num_out(num_out), .index(index), .digit_en(digit_en), .frame_done(frame_done)
    );

    scan_display_n #(.NUM_DIGITS(3), .DIGIT_W(4), .PRESCALE(4)) dut2 (
        .scan_clk(clk), .rst(rst2), .en(en2), .num_in(num_in2), .blank_mask(blank2),
        .num_out(num_out2), .index(index2), .digit_en(digit_en2), .frame_done(frame_done2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit          rst;
        bit          en;
        logic [15:0] num;
        logic [3:0]  blank;
        int          idx;
        int          nout;
        logic [3:0]  den;
        bit          fd;
    } vec_t;

    typedef struct {
        string name;
        int    idx;
        int    nout;
        int    den;
        bit    fd;
    } exp_t;

    vec_t vt[$];
    exp_t exp_q[$];

    task automatic row(input bit r, input bit e, input logic [15:0] n, input logic [3:0] b,
                       input int i, input int no, input logic [3:0] d, input bit f);
        vt.push_back('{r, e, n, b, i, no, d, f});
    endtask

    task automatic check_pop(input int a_idx, input int a_num, input int a_den, input bit a_fd);
        exp_t x;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty: no expected entry for actual idx=%0d num=%0d den=%b fd=%0d",
                     a_idx, a_num, a_den, a_fd);
        end else begin
            x = exp_q.pop_front();
            if (a_idx != x.idx || a_num != x.nout || a_den != x.den || a_fd != x.fd) begin
                bad++;
                $display("FAIL %s: actual idx=%0d num=%0d den=%b fd=%0d, required idx=%0d num=%0d den=%b fd=%0d",
                         x.name, a_idx, a_num, a_den, a_fd, x.idx, x.nout, x.den, x.fd);
            end
        end
    endtask

    initial begin
        int cnt, steps, e_idx;
        rst = 1'b1; en = 1'b1; num_in = 16'h4321; blank_mask = '0;
        rst2 = 1'b1; en2 = 1'b0; num_in2 = 12'h321; blank2 = '0;

        // reset, basic scan of 4321
        row(1, 1, 16'h4321, 4'b0000, 3, 0, 4'b0000, 0);
        row(0, 1, 16'h4321, 4'b0000, 0, 1, 4'b0001, 1);
        row(0, 1, 16'h4321, 4'b0000, 1, 2, 4'b0010, 0);
        row(0, 1, 16'h4321, 4'b0000, 2, 3, 4'b0100, 0);
        row(0, 1, 16'h4321, 4'b0000, 3, 4, 4'b1000, 0);
        row(0, 1, 16'h4321, 4'b0000, 0, 1, 4'b0001, 1);
        // en low holds everything even with input changes
        row(0, 0, 16'h4321, 4'b0000, 0, 1, 4'b0001, 0);
        row(0, 0, 16'h9999, 4'b0000, 0, 1, 4'b0001, 0);
        row(0, 1, 16'h9999, 4'b0000, 1, 2, 4'b0010, 0);
        row(0, 1, 16'h1111, 4'b0000, 2, 3, 4'b0100, 0);
        row(0, 1, 16'h1111, 4'b0000, 3, 4, 4'b1000, 0);
        // 1111 frame, changed to 9999 at index 1
        row(0, 1, 16'h1111, 4'b0000, 0, 1, 4'b0001, 1);
        row(0, 1, 16'h1111, 4'b0000, 1, 1, 4'b0010, 0);
        row(0, 1, 16'h9999, 4'b0000, 2, 1, 4'b0100, 0);
        row(0, 1, 16'h9999, 4'b0000, 3, 1, 4'b1000, 0);
        row(0, 1, 16'h9999, 4'b0000, 0, 9, 4'b0001, 1);
        row(0, 1, 16'h9999, 4'b0000, 1, 9, 4'b0010, 0);
        // blank digit 2 of a 5555 frame
        row(0, 1, 16'h5555, 4'b0100, 2, 9, 4'b0100, 0);
        row(0, 1, 16'h5555, 4'b0100, 3, 9, 4'b1000, 0);
        row(0, 1, 16'h5555, 4'b0100, 0, 5, 4'b0001, 1);
        row(0, 1, 16'h5555, 4'b0000, 1, 5, 4'b0010, 0);
        row(0, 1, 16'h5555, 4'b0000, 2, 5, 4'b0000, 0);
        row(0, 1, 16'h5555, 4'b0000, 3, 5, 4'b1000, 0);
        row(0, 1, 16'h5555, 4'b0000, 0, 5, 4'b0001, 1);
        // reset mid-frame at index 2
        row(0, 1, 16'h5555, 4'b0000, 1, 5, 4'b0010, 0);
        row(0, 1, 16'h5555, 4'b0000, 2, 5, 4'b0100, 0);
        row(1, 1, 16'h4321, 4'b0000, 3, 0, 4'b0000, 0);
        row(0, 1, 16'h4321, 4'b0000, 0, 1, 4'b0001, 1);
        row(1, 0, 16'h4321, 4'b0000, 3, 0, 4'b0000, 0);
        // leading zeros: dark only when suppression is built in
        row(0, 1, 16'h0070, 4'b0000, 0, 0, 4'b0001, 1);
        row(0, 1, 16'h0070, 4'b0000, 1, 7, 4'b0010, 0);
        row(0, 1, 16'h0070, 4'b0000, 2, 0, LZ ? 4'b0000 : 4'b0100, 0);
        row(0, 1, 16'h0000, 4'b0000, 3, 0, LZ ? 4'b0000 : 4'b1000, 0);
        row(0, 1, 16'h0000, 4'b0000, 0, 0, 4'b0001, 1);
        row(0, 1, 16'h0000, 4'b0000, 1, 0, LZ ? 4'b0000 : 4'b0010, 0);
        row(0, 1, 16'h0000, 4'b0000, 2, 0, LZ ? 4'b0000 : 4'b0100, 0);
        row(0, 1, 16'h0000, 4'b0000, 3, 0, LZ ? 4'b0000 : 4'b1000, 0);

        foreach (vt[i]) begin
            @(negedge clk);
            rst = vt[i].rst; en = vt[i].en; num_in = vt[i].num; blank_mask = vt[i].blank;
            exp_q.push_back('{$sformatf("vec%0d", i), vt[i].idx, vt[i].nout,
                               int'(vt[i].den), vt[i].fd});
            @(posedge clk);
            #1 check_pop(int'(index), int'(num_out), int'(digit_en), frame_done);
        end

        // 3-digit instance, PRESCALE=4, with a 5-cycle en-low freeze
        @(negedge clk);
        rst2 = 1'b1; en2 = 1'b1;
        exp_q.push_back('{"n3_reset", 2, 0, 0, 1'b0});
        @(posedge clk);
        #1 check_pop(int'(index2), int'(num_out2), int'(digit_en2), frame_done2);
        cnt = 0;
        for (int c = 0; c < 28; c++) begin
            @(negedge clk);
            rst2 = 1'b0;
            en2 = !(c >= 18 && c < 23);
            if (en2) cnt++;
            steps = cnt / 4;
            e_idx = (steps == 0) ? 2 : (steps - 1) % 3;
            exp_q.push_back('{$sformatf("n3_cyc%0d", c), e_idx,
                               (steps == 0) ? 0 : e_idx + 1,
                               (steps == 0) ? 0 : (1 << e_idx),
                               en2 && cnt > 0 && (cnt % 4 == 0) && ((steps - 1) % 3 == 0)});
            @(posedge clk);
            #1 check_pop(int'(index2), int'(num_out2), int'(digit_en2), frame_done2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
